// File: rtl/prbs_pkg.sv
// Shared types and polynomial helpers for the PRBS checker and its LFSR.
// Supported generators: PRBS7 (x^7+x^6+1), PRBS15 (x^15+x^14+1), PRBS31 (x^31+x^28+1).
package prbs_pkg;

    typedef enum logic [1:0] {
        SEEK   = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } state_e;

    typedef struct packed {
        logic [5:0] t1;
        logic [5:0] t2;
    } taps_t;

    function automatic bit prbs_order_legal(input int order);
        return (order == 7) || (order == 15) || (order == 31);
    endfunction

    function automatic taps_t prbs_taps(input int order);
        taps_t t;
        case (order)
            15: begin
                t.t1 = 6'd15;
                t.t2 = 6'd14;
            end
            31: begin
                t.t1 = 6'd31;
                t.t2 = 6'd28;
            end
            default: begin
                t.t1 = 6'd7;
                t.t2 = 6'd6;
            end
        endcase
        return t;
    endfunction

endpackage

// File: rtl/prbs_lfsr.sv
// PRBS shift register with predicted-bit output; s[0] holds the newest bit.
// Loads either the received bit (acquisition) or its own prediction (free-run).
module prbs_lfsr
    import prbs_pkg::*;
#(
    parameter int ORDER = 7
) (
    input  logic clock,
    input  logic reset,
    input  logic shift_en,
    input  logic load_pred,
    input  logic bit_in,
    output logic pred
);

    localparam taps_t TAPS = prbs_taps(ORDER);
    localparam int    T1   = int'(TAPS.t1);
    localparam int    T2   = int'(TAPS.t2);

    logic [ORDER-1:0] s_q;
    logic [ORDER-1:0] s_d;

    assign pred = s_q[T1-1] ^ s_q[T2-1];

    always_comb begin
        s_d = s_q;
        if (shift_en) begin
            s_d = {s_q[ORDER-2:0], load_pred ? pred : bit_in};
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            s_q <= '0;
        end else begin
            s_q <= s_d;
        end
    end

endmodule

// File: rtl/prbs_checker.sv
// Self-synchronising serial PRBS checker: acquires lock, then free-runs and
// counts bit errors and invalid differential symbols; drops lock on error bursts.
module prbs_checker
    import prbs_pkg::*;
#(
    parameter int PRBS_ORDER  = 7,
    parameter int LOCK_COUNT  = 16,
    parameter int WINDOW      = 128,
    parameter int UNLOCK_ERRS = 8,
    parameter int ERR_W       = 32,
    parameter int CNT_W       = 48
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_p,
    input  logic             in_n,
    input  logic             enable,
    input  logic             clear,
    output logic             locked,
    output logic             err_pulse,
    output logic [ERR_W-1:0] error_count,
    output logic [CNT_W-1:0] bit_count,
    output state_e           state_dbg
);

    generate
        if (!prbs_order_legal(PRBS_ORDER)) begin : g_bad_order
            $error("prbs_checker: PRBS_ORDER must be 7, 15 or 31");
        end
        if ((WINDOW < 2) || ((WINDOW & (WINDOW - 1)) != 0)) begin : g_bad_window
            $error("prbs_checker: WINDOW must be a power of two, at least 2");
        end
        if ((UNLOCK_ERRS < 1) || (UNLOCK_ERRS > WINDOW)) begin : g_bad_unlock
            $error("prbs_checker: UNLOCK_ERRS must lie in 1..WINDOW");
        end
        if (LOCK_COUNT < 1) begin : g_bad_lock
            $error("prbs_checker: LOCK_COUNT must be at least 1");
        end
    endgenerate

    localparam int FILL_W  = $clog2(PRBS_ORDER);
    localparam int MATCH_W = $clog2(LOCK_COUNT + 1);
    localparam int WB_W    = $clog2(WINDOW);
    localparam int WE_W    = $clog2(UNLOCK_ERRS + 1);

    state_e             state_q, state_d;
    logic [FILL_W-1:0]  fill_q, fill_d;
    logic [MATCH_W-1:0] match_q, match_d;
    logic [WB_W-1:0]    win_bits_q, win_bits_d;
    logic [WE_W-1:0]    win_errs_q, win_errs_d;
    logic               locked_q, locked_d;
    logic               err_pulse_q, err_pulse_d;
    logic [ERR_W-1:0]   error_count_q, error_count_d;
    logic [CNT_W-1:0]   bit_count_q, bit_count_d;

    logic               pred;
    logic               sym_invalid;
    logic               sym_err;
    logic               wrap;
    logic [WE_W-1:0]    win_errs_next;

    prbs_lfsr #(
        .ORDER (PRBS_ORDER)
    ) u_lfsr (
        .clock     (clock),
        .reset     (reset),
        .shift_en  (enable),
        .load_pred (state_q == LOCKED),
        .bit_in    (in_p),
        .pred      (pred)
    );

    assign sym_invalid   = (in_p == in_n);
    assign sym_err       = (pred != in_p) || sym_invalid;
    // The bit that wraps win_bits is the first bit of the next window.
    assign wrap          = (win_bits_q == WB_W'(WINDOW - 1));
    assign win_errs_next = (wrap ? '0 : win_errs_q) + WE_W'(sym_err);

    always_comb begin
        state_d       = state_q;
        fill_d        = fill_q;
        match_d       = match_q;
        win_bits_d    = win_bits_q;
        win_errs_d    = win_errs_q;
        locked_d      = locked_q;
        err_pulse_d   = 1'b0;
        error_count_d = error_count_q;
        bit_count_d   = bit_count_q;

        if (enable) begin
            case (state_q)
                SEEK: begin
                    if (fill_q == FILL_W'(PRBS_ORDER - 1)) begin
                        state_d = VERIFY;
                        fill_d  = '0;
                        match_d = '0;
                    end else begin
                        fill_d = fill_q + FILL_W'(1);
                    end
                end

                VERIFY: begin
                    if (sym_err) begin
                        state_d = SEEK;
                        fill_d  = '0;
                    end else if ((match_q + MATCH_W'(1)) == MATCH_W'(LOCK_COUNT)) begin
                        state_d    = LOCKED;
                        locked_d   = 1'b1;
                        win_bits_d = '0;
                        win_errs_d = '0;
                    end else begin
                        match_d = match_q + MATCH_W'(1);
                    end
                end

                LOCKED: begin
                    err_pulse_d = sym_err;
                    win_bits_d  = wrap ? '0 : win_bits_q + WB_W'(1);
                    win_errs_d  = win_errs_next;
                    if (error_count_q != '1) begin
                        error_count_d = error_count_q + ERR_W'(sym_err);
                    end
                    if (bit_count_q != '1) begin
                        bit_count_d = bit_count_q + CNT_W'(1);
                    end
                    // Error burst: the counted errors stay, only the lock is lost.
                    if (win_errs_next >= WE_W'(UNLOCK_ERRS)) begin
                        state_d    = SEEK;
                        fill_d     = '0;
                        locked_d   = 1'b0;
                        win_bits_d = '0;
                        win_errs_d = '0;
                    end
                end

                default: begin
                    state_d  = SEEK;
                    fill_d   = '0;
                    locked_d = 1'b0;
                end
            endcase

            if (clear) begin
                error_count_d = '0;
                bit_count_d   = '0;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= SEEK;
            fill_q        <= '0;
            match_q       <= '0;
            win_bits_q    <= '0;
            win_errs_q    <= '0;
            locked_q      <= 1'b0;
            err_pulse_q   <= 1'b0;
            error_count_q <= '0;
            bit_count_q   <= '0;
        end else begin
            state_q       <= state_d;
            fill_q        <= fill_d;
            match_q       <= match_d;
            win_bits_q    <= win_bits_d;
            win_errs_q    <= win_errs_d;
            locked_q      <= locked_d;
            err_pulse_q   <= err_pulse_d;
            error_count_q <= error_count_d;
            bit_count_q   <= bit_count_d;
        end
    end

    assign locked      = locked_q;
    assign err_pulse   = err_pulse_q;
    assign error_count = error_count_q;
    assign bit_count   = bit_count_q;
    assign state_dbg   = state_q;

endmodule
